conv_bram_loader: RTL and testbench

//  Write side of the convolution engine's image/kernel BRAMs. Accepts a byte stream (valid/ready),

---
 rtl/conv_bram_loader_if.sv | 35 +++
 rtl/conv_bram_loader.sv | 191 +++++++++++++++++++
 tb/tb_conv_bram_loader.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_bram_loader_if.sv
// Byte stream and BRAM write bundle of the convolution BRAM loader.
// master = loader side, slave = stream source / BRAM side.
interface conv_bram_loader_if #(
  parameter int IMG_ADDR_WIDTH  = 8,
  parameter int KERN_ADDR_WIDTH = 6,
  parameter int IMG_DWIDTH      = 24,
  parameter int KERN_DWIDTH     = 24,
  parameter int BYTE_WIDTH      = 8
);
  // Stream: a byte transfers on a rising clk edge where s_valid && s_ready;
  // s_data is sampled only then, and s_valid may drop at any time.
  logic [BYTE_WIDTH-1:0]      s_data;
  logic                       s_valid;
  logic                       s_ready;
  logic                       img_wr_en;
  logic [IMG_ADDR_WIDTH-1:0]  img_wr_addr;
  logic [IMG_DWIDTH-1:0]      img_wr_data;
  logic                       kern_wr_en;
  logic [KERN_ADDR_WIDTH-1:0] kern_wr_addr;
  logic [KERN_DWIDTH-1:0]     kern_wr_data;

  modport master (
    input  s_data, s_valid,
    output s_ready,
    output img_wr_en, img_wr_addr, img_wr_data,
    output kern_wr_en, kern_wr_addr, kern_wr_data
  );

  modport slave (
    output s_data, s_valid,
    input  s_ready,
    input  img_wr_en, img_wr_addr, img_wr_data,
    input  kern_wr_en, kern_wr_addr, kern_wr_data
  );
endinterface

// File: rtl/conv_bram_loader.sv
// Packs a byte stream into 24-bit image then kernel BRAM words, starts the engine, waits for done.
// Optional LOADER_CHECKSUM_EN adds a 16-bit running byte checksum output.
module conv_bram_loader #(
  parameter int IMG_ADDR_WIDTH  = 8,
  parameter int KERN_ADDR_WIDTH = 6,
  parameter int IMG_DWIDTH      = 24,
  parameter int KERN_DWIDTH     = 24,
  parameter int BYTE_WIDTH      = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic [IMG_ADDR_WIDTH-1:0]  img_words,
  input  logic [KERN_ADDR_WIDTH-1:0] kern_words,
  conv_bram_loader_if.master         bus,
  output logic                       conv_start,
  input  logic                       conv_done,
  output logic                       busy,
  output logic                       done,
  output logic [2:0]                 state_dbg
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0]                checksum
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_IMG  = 3'd1,
    LD_KERN = 3'd2,
    START   = 3'd3,
    WAIT    = 3'd4
  } state_t;

  state_t                      state_q, state_d;
  logic [IMG_ADDR_WIDTH-1:0]   img_words_q, img_words_d;
  logic [KERN_ADDR_WIDTH-1:0]  kern_words_q, kern_words_d;
  logic [IMG_ADDR_WIDTH-1:0]   img_cnt_q, img_cnt_d;
  logic [KERN_ADDR_WIDTH-1:0]  kern_cnt_q, kern_cnt_d;
  logic [1:0]                  lane_q, lane_d;
  logic [2*BYTE_WIDTH-1:0]     pack_q, pack_d;
  logic                        img_wr_en_q, img_wr_en_d;
  logic [IMG_ADDR_WIDTH-1:0]   img_wr_addr_q, img_wr_addr_d;
  logic [IMG_DWIDTH-1:0]       img_wr_data_q, img_wr_data_d;
  logic                        kern_wr_en_q, kern_wr_en_d;
  logic [KERN_ADDR_WIDTH-1:0]  kern_wr_addr_q, kern_wr_addr_d;
  logic [KERN_DWIDTH-1:0]      kern_wr_data_q, kern_wr_data_d;
  logic                        done_q, done_d;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0]                 cks_q, cks_d;
`endif

  logic                        s_ready;
  logic                        accept;
  logic                        word_done;
  logic [3*BYTE_WIDTH-1:0]     word;

  assign s_ready   = (state_q == LD_IMG) || (state_q == LD_KERN);
  assign accept    = bus.s_valid && s_ready;
  assign word_done = accept && (lane_q == 2'd2);
  // Lane 0 sits in the LSB, so the byte arriving now is the top lane.
  assign word      = {bus.s_data, pack_q};

  always_comb begin
    state_d        = state_q;
    img_words_d    = img_words_q;
    kern_words_d   = kern_words_q;
    img_cnt_d      = img_cnt_q;
    kern_cnt_d     = kern_cnt_q;
    lane_d         = lane_q;
    pack_d         = pack_q;
    img_wr_en_d    = 1'b0;
    img_wr_addr_d  = img_wr_addr_q;
    img_wr_data_d  = img_wr_data_q;
    kern_wr_en_d   = 1'b0;
    kern_wr_addr_d = kern_wr_addr_q;
    kern_wr_data_d = kern_wr_data_q;
    done_d         = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    cks_d          = cks_q;
    if (accept) cks_d = cks_q + 16'(bus.s_data);
`endif

    if (accept) begin
      lane_d = (lane_q == 2'd2) ? 2'd0 : lane_q + 2'd1;
      if (lane_q == 2'd0) pack_d[BYTE_WIDTH-1:0]            = bus.s_data;
      if (lane_q == 2'd1) pack_d[2*BYTE_WIDTH-1:BYTE_WIDTH] = bus.s_data;
    end

    case (state_q)
      IDLE: begin
        if (load) begin
          img_words_d  = img_words;
          kern_words_d = kern_words;
          img_cnt_d    = '0;
          kern_cnt_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          cks_d        = '0;
`endif
          if (img_words != '0)       state_d = LD_IMG;
          else if (kern_words != '0) state_d = LD_KERN;
          else                       state_d = START;
        end
      end
      LD_IMG: begin
        if (word_done) begin
          img_wr_en_d   = 1'b1;
          img_wr_addr_d = img_cnt_q;
          img_wr_data_d = word;
          img_cnt_d     = img_cnt_q + IMG_ADDR_WIDTH'(1);
          if (img_cnt_q == img_words_q - IMG_ADDR_WIDTH'(1))
            state_d = (kern_words_q != '0) ? LD_KERN : START;
        end
      end
      LD_KERN: begin
        if (word_done) begin
          kern_wr_en_d   = 1'b1;
          kern_wr_addr_d = kern_cnt_q;
          kern_wr_data_d = word;
          kern_cnt_d     = kern_cnt_q + KERN_ADDR_WIDTH'(1);
          if (kern_cnt_q == kern_words_q - KERN_ADDR_WIDTH'(1))
            state_d = START;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (conv_done) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      img_words_q    <= '0;
      kern_words_q   <= '0;
      img_cnt_q      <= '0;
      kern_cnt_q     <= '0;
      lane_q         <= '0;
      pack_q         <= '0;
      img_wr_en_q    <= 1'b0;
      img_wr_addr_q  <= '0;
      img_wr_data_q  <= '0;
      kern_wr_en_q   <= 1'b0;
      kern_wr_addr_q <= '0;
      kern_wr_data_q <= '0;
      done_q         <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      cks_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      img_words_q    <= img_words_d;
      kern_words_q   <= kern_words_d;
      img_cnt_q      <= img_cnt_d;
      kern_cnt_q     <= kern_cnt_d;
      lane_q         <= lane_d;
      pack_q         <= pack_d;
      img_wr_en_q    <= img_wr_en_d;
      img_wr_addr_q  <= img_wr_addr_d;
      img_wr_data_q  <= img_wr_data_d;
      kern_wr_en_q   <= kern_wr_en_d;
      kern_wr_addr_q <= kern_wr_addr_d;
      kern_wr_data_q <= kern_wr_data_d;
      done_q         <= done_d;
`ifdef LOADER_CHECKSUM_EN
      cks_q          <= cks_d;
`endif
    end
  end

  assign bus.s_ready      = s_ready;
  assign bus.img_wr_en    = img_wr_en_q;
  assign bus.img_wr_addr  = img_wr_addr_q;
  assign bus.img_wr_data  = img_wr_data_q;
  assign bus.kern_wr_en   = kern_wr_en_q;
  assign bus.kern_wr_addr = kern_wr_addr_q;
  assign bus.kern_wr_data = kern_wr_data_q;
  assign conv_start       = (state_q == START);
  assign busy             = (state_q != IDLE);
  assign done             = done_q;
  assign state_dbg        = state_q;
`ifdef LOADER_CHECKSUM_EN
  assign checksum         = cks_q;
`endif

endmodule

// File: tb/tb_conv_bram_loader.sv
// Bench for conv_bram_loader: directed scenarios plus random loads against a word-list model.
// Build with LOADER_CHECKSUM_EN defined to also cover the checksum output.
module tb_conv_bram_loader;
  localparam int IAW = 8;
  localparam int KAW = 6;
  localparam int BW  = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           load;
  logic [IAW-1:0] img_words;
  logic [KAW-1:0] kern_words;
  logic           conv_start;
  logic           conv_done;
  logic           busy;
  logic           done;
  logic [2:0]     state_dbg;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0]    checksum;
`endif

  conv_bram_loader_if #(.IMG_ADDR_WIDTH(IAW), .KERN_ADDR_WIDTH(KAW), .IMG_DWIDTH(24),
                        .KERN_DWIDTH(24), .BYTE_WIDTH(BW)) bus ();

  conv_bram_loader #(.IMG_ADDR_WIDTH(IAW), .KERN_ADDR_WIDTH(KAW), .IMG_DWIDTH(24),
                     .KERN_DWIDTH(24), .BYTE_WIDTH(BW)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .img_words  (img_words),
    .kern_words (kern_words),
    .bus        (bus),
    .conv_start (conv_start),
    .conv_done  (conv_done),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_img_q[$];   // {addr, data}
  logic [29:0] exp_kern_q[$];  // {addr, data}
  logic [7:0]  byte_q[$];
  int          img_strobes = 0;
  int          kern_strobes = 0;
  int          start_cycles = 0;
  int          done_pulses = 0;
  int          ready_cycles = 0;
  bit          expect_final_wr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.img_wr_en) begin
        img_strobes++;
        check("img_wr_pending", 32'(exp_img_q.size() > 0), 32'd1);
        if (exp_img_q.size() > 0)
          check("img_wr", {bus.img_wr_addr, bus.img_wr_data}, exp_img_q.pop_front());
      end
      if (bus.kern_wr_en) begin
        kern_strobes++;
        check("kern_wr_pending", 32'(exp_kern_q.size() > 0), 32'd1);
        if (exp_kern_q.size() > 0)
          check("kern_wr", 32'({bus.kern_wr_addr, bus.kern_wr_data}), 32'(exp_kern_q.pop_front()));
      end
      if (conv_start) begin
        start_cycles++;
        check("start_with_final_wr", 32'(bus.img_wr_en | bus.kern_wr_en), 32'(expect_final_wr));
      end
      if (done) done_pulses++;
      if (bus.s_ready) ready_cycles++;
    end
  end

  // ---------------- drivers ----------------
  task automatic fill_seq(input int first, input int n);
    byte_q.delete();
    for (int i = 0; i < n; i++) byte_q.push_back(8'(first + i));
  endtask

  task automatic fill_random(input int n);
    byte_q.delete();
    for (int i = 0; i < n; i++) byte_q.push_back(8'($urandom));
  endtask

  task automatic do_load(input int iw, input int kw);
    load       = 1'b1;
    img_words  = IAW'(iw);
    kern_words = KAW'(kw);
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  // mode 0: valid held high, 1: valid toggles every other cycle, 2: random valid
  task automatic send_byte(input logic [7:0] b, input int mode);
    int tries = 0;
    bit acc = 1'b0;
    bit v;
    while (!acc && tries < 64) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (tries % 2 == 1) : 1'($urandom_range(0, 1));
      bus.s_valid = v;
      bus.s_data  = v ? b : 8'($urandom);
      @(negedge clk);
      acc = v && bus.s_ready;
      @(posedge clk); #1;
      tries++;
    end
    bus.s_valid = 1'b0;
    check("byte_accepted", 32'(acc), 32'd1);
  endtask

  task automatic ignored_events();
    load       = 1'b1;
    img_words  = IAW'(7);
    kern_words = KAW'(0);
    conv_done  = 1'b1;
    @(posedge clk); #1;
    load      = 1'b0;
    conv_done = 1'b0;
    @(negedge clk);
    check("ign_stay_ld_img", 32'(state_dbg), 32'd1);
    check("ign_no_done", 32'(done), 32'd0);
    check("ign_ready", 32'(bus.s_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  // Runs one complete load using the bytes in byte_q; model = word list built from the byte list.
  task automatic run_load(input int iw, input int kw, input int mode, input bit inject);
    int n = 3 * (iw + kw);
    int s_img = img_strobes;
    int s_kern = kern_strobes;
    int s_start = start_cycles;
    int s_done = done_pulses;
    int waited = 0;
    logic [15:0] cks = 16'd0;
    logic [23:0] d;
    for (int w = 0; w < iw + kw; w++) begin
      d = {byte_q[3*w+2], byte_q[3*w+1], byte_q[3*w]};
      if (w < iw) exp_img_q.push_back({8'(w), d});
      else        exp_kern_q.push_back({6'(w - iw), d});
    end
    for (int i = 0; i < n; i++) cks = cks + 16'(byte_q[i]);
    expect_final_wr = (n > 0);
    do_load(iw, kw);
    for (int i = 0; i < n; i++) begin
      if (inject && i == 2) ignored_events();
      send_byte(byte_q[i], mode);
    end
    @(negedge clk);
    while (!conv_start && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    check("start_latency", 32'(waited), 32'd0);
    check("start_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    repeat ($urandom_range(0, 3)) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("wait_outputs", {28'd0, busy, bus.s_ready, conv_start, done}, 32'b1000);
    @(posedge clk); #1;
    conv_done = 1'b1;
    @(posedge clk); #1;
    conv_done = 1'b0;
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    check("done_idle", 32'(busy), 32'd0);
`ifdef LOADER_CHECKSUM_EN
    check("checksum", 32'(checksum), 32'(cks));
`endif
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
`ifdef LOADER_CHECKSUM_EN
    check("checksum_hold", 32'(checksum), 32'(cks));
`endif
    @(posedge clk); #1;
    check("img_strobes", 32'(img_strobes - s_img), 32'(iw));
    check("kern_strobes", 32'(kern_strobes - s_kern), 32'(kw));
    check("start_cycles", 32'(start_cycles - s_start), 32'd1);
    check("done_pulses", 32'(done_pulses - s_done), 32'd1);
    check("img_q_drained", 32'(exp_img_q.size()), 32'd0);
    check("kern_q_drained", 32'(exp_kern_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_img_en_addr"}, 32'({bus.img_wr_en, bus.img_wr_addr}), 32'd0);
    check({tag, "_img_data"}, 32'(bus.img_wr_data), 32'd0);
    check({tag, "_kern_en_addr"}, 32'({bus.kern_wr_en, bus.kern_wr_addr}), 32'd0);
    check({tag, "_kern_data"}, 32'(bus.kern_wr_data), 32'd0);
    check({tag, "_ctrl"}, 32'({bus.s_ready, conv_start, busy, done, state_dbg}), 32'd0);
`ifdef LOADER_CHECKSUM_EN
    check({tag, "_checksum"}, 32'(checksum), 32'd0);
`endif
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int s_img;
    int rdy0;
    reset       = 1'b1;
    load        = 1'b0;
    img_words   = '0;
    kern_words  = '0;
    conv_done   = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // basic load, valid held high
    fill_seq(1, 9);
    run_load(2, 1, 0, 1'b0);
    // same stream with back-pressure
    fill_seq(1, 9);
    run_load(2, 1, 1, 1'b0);
    // zero image count
    fill_seq(1, 3);
    run_load(0, 1, 0, 1'b0);
    // both counts zero: stream never opened
    rdy0 = ready_cycles;
    byte_q.delete();
    run_load(0, 0, 0, 1'b0);
    check("zero_no_ready", 32'(ready_cycles - rdy0), 32'd0);
    // load and conv_done pulsed mid image load
    fill_random(9);
    run_load(2, 1, 2, 1'b1);

    // reset after 4 bytes of a 2-word image
    s_img = img_strobes;
    byte_q.delete();
    byte_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_img_q.push_back({8'd0, 24'h332211});
    do_load(2, 0);
    for (int i = 0; i < 4; i++) send_byte(byte_q[i], 0);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("midrst_rel");
    check("midrst_strobes", 32'(img_strobes - s_img), 32'd1);
    check("midrst_q", 32'(exp_img_q.size()), 32'd0);
    @(posedge clk); #1;
    byte_q.delete();
    byte_q = '{8'hAA, 8'hBB, 8'hCC};
    run_load(1, 0, 0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    byte_q.delete();
    byte_q = '{8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h03};
    run_load(1, 1, 0, 1'b0);
    check("checksum_directed", 32'(checksum), 32'h0303);
`endif

    // random loads
    for (int k = 0; k < 8; k++) begin
      int iw = $urandom_range(0, 5);
      int kw = $urandom_range(0, 4);
      fill_random(3 * (iw + kw));
      run_load(iw, kw, $urandom_range(0, 2), 1'b0);
    end
    // maximum counts
    fill_random(3 * (255 + 63));
    run_load(255, 63, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
